mem_port_arbiter: RTL and testbench

Sequencer and arbiter for the single byte-wide RAM port shared by instruction fetch (IF) and the load/store (MEM) stage. It accepts word-level requests from both clients and breaks each into little-endian byte accesses on the RAM port. It assembles read bytes into a 32-bit result and returns a one-cycle done pulse to the owning client. It sits between the IF/MEM pipeline stages and the RAM, replacing per-stage byte sequencing.

---
 rtl/mem_port_arbiter_pkg.sv | 33 +++
 rtl/mem_port_arbiter_if.sv | 44 ++++
 rtl/mem_port_arbiter.sv | 169 ++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// rtl/mem_port_arbiter_pkg.sv - shared encodings for the IF/MEM byte-port arbiter
package mem_port_arbiter_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  // Cycles between driving a RAM address and its byte appearing on ram_din_i.
  localparam int RAM_RD_LAT = 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_XFER,
    ST_DRAIN,
    ST_DONE
  } state_e;

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_IF,
    OWN_MEM
  } owner_e;

  // Byte count of an access; the reserved encoding 11 behaves as a word.
  function automatic logic [2:0] size_to_len(input logic [1:0] size);
    case (size)
      SZ_BYTE: return 3'd1;
      SZ_HALF: return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - client and RAM signal bundle for mem_port_arbiter
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32
);
  logic              if_req_i;
  logic [ADDR_W-1:0] if_addr_i;
  logic              if_flush_i;
  logic              if_done_o;
  logic [31:0]       if_data_o;

  logic              mem_req_i;
  logic              mem_we_i;
  logic [1:0]        mem_size_i;
  logic [ADDR_W-1:0] mem_addr_i;
  logic [31:0]       mem_wdata_i;
  logic              mem_done_o;
  logic [31:0]       mem_rdata_o;
  logic              mem_stall_o;

  logic [ADDR_W-1:0] ram_addr_o;
  logic              ram_wr_o;
  logic [7:0]        ram_dout_o;
  logic [7:0]        ram_din_i;

  // Arbiter side.
  modport slave (
    input  if_req_i, if_addr_i, if_flush_i,
    output if_done_o, if_data_o,
    input  mem_req_i, mem_we_i, mem_size_i, mem_addr_i, mem_wdata_i,
    output mem_done_o, mem_rdata_o, mem_stall_o,
    output ram_addr_o, ram_wr_o, ram_dout_o,
    input  ram_din_i
  );

  // Clients and RAM side.
  modport master (
    output if_req_i, if_addr_i, if_flush_i,
    input  if_done_o, if_data_o,
    output mem_req_i, mem_we_i, mem_size_i, mem_addr_i, mem_wdata_i,
    input  mem_done_o, mem_rdata_o, mem_stall_o,
    input  ram_addr_o, ram_wr_o, ram_dout_o,
    output ram_din_i
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - byte-serial sequencer/arbiter for the shared IF/MEM RAM port
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input logic               clk,
  input logic               rst,
  mem_port_arbiter_if.slave bus
);

  state_e            state_q, state_d;
  owner_e            owner_q, owner_d;
  logic [1:0]        cnt_q, cnt_d;
  logic [2:0]        len_q, len_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       acc_q, acc_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic              ram_wr_q, ram_wr_d;
  logic [7:0]        ram_dout_q, ram_dout_d;
  logic [31:0]       if_data_q, if_data_d;
  logic [31:0]       mem_rdata_q, mem_rdata_d;

  logic [1:0]  cnt_n;
  logic [1:0]  rd_idx;
  logic [31:0] merged;
  logic        last_issue;
  logic        if_flush_hit;

  // Byte arriving now belongs to the address issued one cycle earlier.
  always_comb begin
    cnt_n        = cnt_q + 2'd1;
    rd_idx       = (state_q == ST_DRAIN) ? 2'(len_q - 3'd1) : 2'(cnt_q - 2'd1);
    merged       = acc_q | (32'(bus.ram_din_i) << {rd_idx, 3'b000});
    last_issue   = ({1'b0, cnt_q} == (len_q - 3'd1));
    if_flush_hit = (owner_q == OWN_IF) && bus.if_flush_i;
  end

  // Arbitration, byte sequencing and read assembly.
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    cnt_d       = cnt_q;
    len_d       = len_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    acc_d       = acc_q;
    ram_addr_d  = ram_addr_q;
    ram_wr_d    = 1'b0;
    ram_dout_d  = ram_dout_q;
    if_data_d   = if_data_q;
    mem_rdata_d = mem_rdata_q;

    case (state_q)
      ST_IDLE: begin
        owner_d = OWN_NONE;
        if (bus.mem_req_i) begin
          // MEM has priority so the pipeline stall clears as early as possible.
          state_d    = ST_XFER;
          owner_d    = OWN_MEM;
          cnt_d      = 2'd0;
          len_d      = size_to_len(bus.mem_size_i);
          we_d       = bus.mem_we_i;
          addr_d     = bus.mem_addr_i;
          wdata_d    = bus.mem_wdata_i;
          acc_d      = 32'd0;
          ram_addr_d = bus.mem_addr_i;
          ram_wr_d   = bus.mem_we_i;
          ram_dout_d = bus.mem_wdata_i[7:0];
        end else if (bus.if_req_i && !bus.if_flush_i) begin
          state_d    = ST_XFER;
          owner_d    = OWN_IF;
          cnt_d      = 2'd0;
          len_d      = 3'd4;
          we_d       = 1'b0;
          addr_d     = bus.if_addr_i;
          wdata_d    = 32'd0;
          acc_d      = 32'd0;
          ram_addr_d = bus.if_addr_i;
        end
      end

      ST_XFER: begin
        if (if_flush_hit) begin
          state_d = ST_IDLE;
          owner_d = OWN_NONE;
        end else begin
          if (!we_q && cnt_q != 2'd0) begin
            acc_d = merged;
          end
          if (last_issue) begin
            state_d = we_q ? ST_DONE : ST_DRAIN;
          end else begin
            cnt_d      = cnt_n;
            ram_addr_d = addr_q + ADDR_W'(cnt_n);
            ram_wr_d   = we_q;
            ram_dout_d = 8'(wdata_q >> {cnt_n, 3'b000});
          end
        end
      end

      ST_DRAIN: begin
        if (if_flush_hit) begin
          state_d = ST_IDLE;
          owner_d = OWN_NONE;
        end else begin
          acc_d   = merged;
          state_d = ST_DONE;
          if (owner_q == OWN_IF) begin
            if_data_d = merged;
          end else begin
            mem_rdata_d = merged;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
        owner_d = OWN_NONE;
      end
    endcase
  end

  // State and output registers; reset also clears any half-finished transfer.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      owner_q     <= OWN_NONE;
      cnt_q       <= 2'd0;
      len_q       <= 3'd0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= 32'd0;
      acc_q       <= 32'd0;
      ram_addr_q  <= '0;
      ram_wr_q    <= 1'b0;
      ram_dout_q  <= 8'd0;
      if_data_q   <= 32'd0;
      mem_rdata_q <= 32'd0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      cnt_q       <= cnt_d;
      len_q       <= len_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      acc_q       <= acc_d;
      ram_addr_q  <= ram_addr_d;
      ram_wr_q    <= ram_wr_d;
      ram_dout_q  <= ram_dout_d;
      if_data_q   <= if_data_d;
      mem_rdata_q <= mem_rdata_d;
    end
  end

  assign bus.if_done_o   = (state_q == ST_DONE) && (owner_q == OWN_IF);
  assign bus.mem_done_o  = (state_q == ST_DONE) && (owner_q == OWN_MEM);
  assign bus.if_data_o   = if_data_q;
  assign bus.mem_rdata_o = mem_rdata_q;
  assign bus.mem_stall_o = bus.mem_req_i && !bus.mem_done_o;
  assign bus.ram_addr_o  = ram_addr_q;
  assign bus.ram_wr_o    = ram_wr_q;
  assign bus.ram_dout_o  = ram_dout_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed vector bench for mem_port_arbiter
module tb_mem_port_arbiter;
  import mem_port_arbiter_pkg::*;

  typedef struct {
    logic        is_mem;
    logic        we;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] ram_bytes;
    int          exp_lat;
    logic [31:0] exp_data;
  } vec_t;

  logic clk;
  logic rst;
  int   total = 0;
  int   bad = 0;
  logic [7:0] ram [0:1023];
  vec_t vecs [10];

  mem_port_arbiter_if #(.ADDR_W(32)) bus ();

  mem_port_arbiter #(.ADDR_W(32)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Byte RAM with one cycle of read latency.
  always @(posedge clk) begin
    bus.ram_din_i <= ram[bus.ram_addr_o[9:0]];
    if (bus.ram_wr_o) ram[bus.ram_addr_o[9:0]] = bus.ram_dout_o;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic preload(input logic [31:0] addr, input logic [31:0] word);
    logic [31:0] a;
    for (int b = 0; b < 4; b++) begin
      a = addr + 32'(b);
      ram[a[9:0]] = word[8*b +: 8];
    end
  endtask

  function automatic logic [31:0] peek(input logic [31:0] addr);
    logic [31:0] a;
    logic [31:0] w;
    w = 32'd0;
    for (int b = 0; b < 4; b++) begin
      a = addr + 32'(b);
      w[8*b +: 8] = ram[a[9:0]];
    end
    return w;
  endfunction

  task automatic wait_done(input logic is_mem, output int lat);
    lat = 0;
    do begin
      step();
      lat++;
    end while (!(is_mem ? bus.mem_done_o : bus.if_done_o) && lat < 20);
  endtask

  initial begin
    int lat;
    logic seen;

    vecs[0] = '{1'b0, 1'b0, SZ_WORD, 32'h0000_1000, 32'h0, 32'h0000_0513, 6, 32'h0000_0513};
    vecs[1] = '{1'b1, 1'b0, SZ_WORD, 32'h0000_0040, 32'h0, 32'h1122_3344, 6, 32'h1122_3344};
    vecs[2] = '{1'b1, 1'b0, SZ_HALF, 32'h0000_0050, 32'h0, 32'hAABB_CCDD, 4, 32'h0000_CCDD};
    vecs[3] = '{1'b1, 1'b0, SZ_BYTE, 32'h0000_0030, 32'h0, 32'h0000_0080, 3, 32'h0000_0080};
    vecs[4] = '{1'b1, 1'b0, 2'b11,   32'h0000_0061, 32'h0, 32'hCAFE_F00D, 6, 32'hCAFE_F00D};
    vecs[5] = '{1'b1, 1'b1, SZ_WORD, 32'h0000_0020, 32'hDEAD_BEEF, 32'h0, 5, 32'hDEAD_BEEF};
    vecs[6] = '{1'b1, 1'b1, SZ_HALF, 32'h0000_0070, 32'h1234_5678, 32'hFFFF_FFFF, 3, 32'hFFFF_5678};
    vecs[7] = '{1'b1, 1'b1, SZ_BYTE, 32'h0000_0080, 32'hA5A5_A5C3, 32'h1111_1111, 2, 32'h1111_11C3};
    vecs[8] = '{1'b1, 1'b0, SZ_HALF, 32'hFFFF_FFFF, 32'h0, 32'h9988_BBAA, 4, 32'h0000_BBAA};
    vecs[9] = '{1'b0, 1'b0, SZ_WORD, 32'hFFFF_FFFE, 32'h0, 32'h0403_0201, 6, 32'h0403_0201};

    for (int i = 0; i < 1024; i++) ram[i] = 8'h00;
    rst = 1'b1;
    bus.if_req_i = 1'b0;   bus.if_addr_i = 32'h0;   bus.if_flush_i = 1'b0;
    bus.mem_req_i = 1'b0;  bus.mem_we_i = 1'b0;     bus.mem_size_i = 2'b00;
    bus.mem_addr_i = 32'h0; bus.mem_wdata_i = 32'h0;
    repeat (3) step();
    rst = 1'b0;
    step();

    check("rst_if_done", bus.if_done_o, 0);
    check("rst_if_data", bus.if_data_o, 0);
    check("rst_mem_done", bus.mem_done_o, 0);
    check("rst_mem_rdata", bus.mem_rdata_o, 0);
    check("rst_mem_stall", bus.mem_stall_o, 0);
    check("rst_ram_addr", bus.ram_addr_o, 0);
    check("rst_ram_wr", bus.ram_wr_o, 0);
    check("rst_ram_dout", bus.ram_dout_o, 0);

    // Single transactions: latency from the accept cycle and resulting data.
    for (int i = 0; i < 10; i++) begin
      preload(vecs[i].addr, vecs[i].ram_bytes);
      if (vecs[i].is_mem) begin
        bus.mem_req_i = 1'b1; bus.mem_we_i = vecs[i].we; bus.mem_size_i = vecs[i].size;
        bus.mem_addr_i = vecs[i].addr; bus.mem_wdata_i = vecs[i].wdata;
      end else begin
        bus.if_req_i = 1'b1; bus.if_addr_i = vecs[i].addr;
      end
      wait_done(vecs[i].is_mem, lat);
      check($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].exp_lat));
      if (!vecs[i].is_mem)     check($sformatf("vec%0d_if_data", i), bus.if_data_o, vecs[i].exp_data);
      else if (!vecs[i].we)    check($sformatf("vec%0d_mem_rdata", i), bus.mem_rdata_o, vecs[i].exp_data);
      else                     check($sformatf("vec%0d_ram_word", i), peek(vecs[i].addr), vecs[i].exp_data);
      bus.if_req_i = 1'b0;
      bus.mem_req_i = 1'b0;
      step();
    end

    // IF fetch address sequence.
    preload(32'h1000, 32'h0000_0513);
    bus.if_addr_i = 32'h1000; bus.if_req_i = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      step();
      check($sformatf("fetch_addr_a%0d", c), bus.ram_addr_o, 32'h1000 + 32'(c - 1));
      check($sformatf("fetch_wr_a%0d", c), bus.ram_wr_o, 0);
    end
    step();
    check("fetch_done_a5", bus.if_done_o, 0);
    step();
    check("fetch_done_a6", bus.if_done_o, 1);
    check("fetch_data_a6", bus.if_data_o, 32'h0000_0513);
    bus.if_req_i = 1'b0;
    step();

    // Word store strobes.
    bus.mem_req_i = 1'b1; bus.mem_we_i = 1'b1; bus.mem_size_i = SZ_WORD;
    bus.mem_addr_i = 32'h20; bus.mem_wdata_i = 32'hDEAD_BEEF;
    for (int c = 1; c <= 4; c++) begin
      step();
      check($sformatf("store_wr_a%0d", c), bus.ram_wr_o, 1);
      check($sformatf("store_addr_a%0d", c), bus.ram_addr_o, 32'h20 + 32'(c - 1));
      check($sformatf("store_byte_a%0d", c), bus.ram_dout_o, (32'hDEAD_BEEF >> (8 * (c - 1))) & 32'hFF);
    end
    step();
    check("store_wr_a5", bus.ram_wr_o, 0);
    check("store_done_a5", bus.mem_done_o, 1);
    bus.mem_req_i = 1'b0; bus.mem_we_i = 1'b0;
    step();

    // Simultaneous requests: MEM byte load first, IF right after.
    preload(32'h30, 32'h0000_0080);
    bus.mem_req_i = 1'b1; bus.mem_size_i = SZ_BYTE; bus.mem_addr_i = 32'h30;
    bus.if_req_i = 1'b1; bus.if_addr_i = 32'h1000;
    step();
    check("both_addr_a1", bus.ram_addr_o, 32'h30);
    step();
    step();
    check("both_mem_done_a3", bus.mem_done_o, 1);
    check("both_if_done_a3", bus.if_done_o, 0);
    check("both_rdata_a3", bus.mem_rdata_o, 32'h0000_0080);
    bus.mem_req_i = 1'b0;
    step();
    check("both_addr_hold_a4", bus.ram_addr_o, 32'h30);
    step();
    check("both_if_addr_a5", bus.ram_addr_o, 32'h1000);
    wait_done(1'b0, lat);
    check("both_if_latency", 32'(lat), 32'd5);
    bus.if_req_i = 1'b0;
    step();

    // MEM request arriving in A+2 of an IF fetch.
    preload(32'h34, 32'h0000_005A);
    bus.if_addr_i = 32'h1000; bus.if_req_i = 1'b1;
    step();
    step();
    bus.mem_req_i = 1'b1; bus.mem_size_i = SZ_BYTE; bus.mem_addr_i = 32'h34;
    #1;
    check("mid_stall_a2", bus.mem_stall_o, 1);
    for (int c = 3; c <= 6; c++) begin
      step();
      check($sformatf("mid_stall_a%0d", c), bus.mem_stall_o, 1);
      check($sformatf("mid_if_done_a%0d", c), bus.if_done_o, (c == 6) ? 1 : 0);
    end
    check("mid_if_data", bus.if_data_o, 32'h0000_0513);
    bus.if_req_i = 1'b0;
    step();
    check("mid_stall_a7", bus.mem_stall_o, 1);
    step();
    check("mid_mem_addr_a8", bus.ram_addr_o, 32'h34);
    step();
    check("mid_mem_done_a9", bus.mem_done_o, 0);
    step();
    check("mid_mem_done_a10", bus.mem_done_o, 1);
    check("mid_stall_a10", bus.mem_stall_o, 0);
    check("mid_rdata", bus.mem_rdata_o, 32'h0000_005A);
    bus.mem_req_i = 1'b0;
    step();

    // Flush in A+3 of a fetch, then refetch from 0x2000.
    preload(32'h2000, 32'h0FF0_0FF0);
    bus.if_addr_i = 32'h1000; bus.if_req_i = 1'b1;
    step();
    step();
    step();
    bus.if_flush_i = 1'b1;
    step();
    check("flush_done_a4", bus.if_done_o, 0);
    check("flush_addr_hold_a4", bus.ram_addr_o, 32'h1002);
    check("flush_data_kept", bus.if_data_o, 32'h0000_0513);
    bus.if_flush_i = 1'b0; bus.if_addr_i = 32'h2000;
    step();
    check("refetch_addr_a1", bus.ram_addr_o, 32'h2000);
    wait_done(1'b0, lat);
    check("refetch_latency", 32'(lat), 32'd5);
    check("refetch_data", bus.if_data_o, 32'h0FF0_0FF0);
    bus.if_req_i = 1'b0;
    step();

    // Reset in A+1 of a halfword store.
    preload(32'h90, 32'hFFFF_FFFF);
    bus.mem_req_i = 1'b1; bus.mem_we_i = 1'b1; bus.mem_size_i = SZ_HALF;
    bus.mem_addr_i = 32'h90; bus.mem_wdata_i = 32'h0000_1234;
    step();
    check("rstx_wr_a1", bus.ram_wr_o, 1);
    rst = 1'b1; bus.mem_req_i = 1'b0; bus.mem_we_i = 1'b0;
    step();
    check("rstx_wr_a2", bus.ram_wr_o, 0);
    check("rstx_ram_addr", bus.ram_addr_o, 0);
    check("rstx_ram_dout", bus.ram_dout_o, 0);
    check("rstx_if_data", bus.if_data_o, 0);
    check("rstx_mem_rdata", bus.mem_rdata_o, 0);
    check("rstx_mem_stall", bus.mem_stall_o, 0);
    rst = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 6; c++) begin
      if (bus.mem_done_o || bus.ram_wr_o) seen = 1'b1;
      step();
    end
    check("rstx_no_done", seen, 0);
    check("rstx_ram_word", peek(32'h90), 32'hFFFF_FF34);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
